// File: rtl/cube_seq_ctrl_if.sv
// Move-push and motor-dispatch handshake bundle for cube_seq_ctrl.
// The sequencer uses the master view; the solver/driver side uses the slave view.
interface cube_seq_ctrl_if #(
    parameter int MOVE_W   = 4,
    parameter int N_MOTORS = 6
);
    logic                mv_valid;
    logic [MOVE_W-1:0]   mv_data;
    logic                mv_ready;
    logic                drv_valid;
    logic                drv_ready;
    logic [N_MOTORS-1:0] drv_en;
    logic                drv_dir;
    logic                drv_done;

    modport master (
        input  mv_valid, mv_data, drv_ready, drv_done,
        output mv_ready, drv_valid, drv_en, drv_dir
    );

    modport slave (
        output mv_valid, mv_data, drv_ready, drv_done,
        input  mv_ready, drv_valid, drv_en, drv_dir
    );
endinterface

// File: rtl/cube_seq_ctrl.sv
// Cube solver sequencer: queues solver moves, then dispatches them one by one to the face motors.
// Optional macro CUBE_SEQ_TIMEOUT_EN adds a watchdog on driver completion (S_ERROR on expiry).
module cube_seq_ctrl #(
    parameter int N_MOTORS    = 6,
    parameter int DEPTH       = 256,
    parameter int MOVE_W      = 4,
    parameter int TIMEOUT_CYC = 12000000
) (
    input  logic                       i_clk_12m,
    input  logic                       i_rst_n,
    input  logic                       i_sense_start,
    input  logic                       i_run_start,
    input  logic                       i_step_mode,
    input  logic                       i_abort,
    input  logic                       i_sd_done,
    input  logic                       i_alg_finish,
    cube_seq_ctrl_if.master            bus,
    output logic [4:0]                 o_state,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_illegal,
    output logic                       o_error
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = MOVE_W - 1;

    if (N_MOTORS < 1 || N_MOTORS > 8 || DEPTH < 4 || DEPTH > 1024 ||
        (DEPTH & (DEPTH - 1)) != 0 || MOVE_W < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("cube_seq_ctrl: unsupported parameter set");
    end

    // State encodings double as the o_state phase code.
    typedef enum logic [4:0] {
        S_INIT   = 5'b00001,
        S_SOLVE  = 5'b00011,
        S_IDLE   = 5'b00111,
        S_ROTATE = 5'b01111,
        S_DONE   = 5'b11111,
        S_ERROR  = 5'b10000
    } state_t;

    typedef enum logic [1:0] {R_DISP, R_WAIT, R_HOLD} rot_t;

    state_t              state;
    rot_t                rot;
    logic                drv_valid;
    logic                drv_dir;
    logic [N_MOTORS-1:0] drv_en;
    logic                illegal;

    logic [MOVE_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;

    logic [MOVE_W-1:0]   head;
    logic [FW-1:0]       head_face;
    logic                head_bad;
    logic [N_MOTORS-1:0] head_en;
    logic                empty;
    logic                full;
    logic                mv_ready;
    logic                abort_evt;
    logic                flush;
    logic                push;
    logic                pop;

`ifdef CUBE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;
    logic          error_q;
    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    assign abort_evt = i_abort && (state != S_INIT);
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign mv_ready  = (state == S_SOLVE) && !full;
    assign push      = bus.mv_valid && mv_ready && !abort_evt;
    assign flush     = abort_evt || ((state == S_DONE) && i_run_start);

    assign head      = mem[rd_ptr];
    assign head_face = head[MOVE_W-1:1];
    assign head_bad  = (32'(head_face) >= 32'(N_MOTORS));

    // An offered move leaves the queue on accept; an illegal head leaves it without being offered.
    assign pop = !abort_evt && (state == S_ROTATE) && (rot == R_DISP) &&
                 (drv_valid ? bus.drv_ready : (!empty && head_bad));

    always_comb begin
        head_en = '0;
        for (int i = 0; i < N_MOTORS; i++) begin
            head_en[i] = (32'(head_face) == 32'(i));
        end
    end

    always_ff @(posedge i_clk_12m) begin
        if (push) mem[wr_ptr] <= bus.mv_data;
    end

    always_ff @(posedge i_clk_12m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk_12m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_INIT;
            rot       <= R_DISP;
            drv_valid <= 1'b0;
            drv_en    <= '0;
            drv_dir   <= 1'b0;
            illegal   <= 1'b0;
`ifdef CUBE_SEQ_TIMEOUT_EN
            wait_cnt  <= '0;
            error_q   <= 1'b0;
`endif
        end else if (abort_evt) begin
            state     <= S_INIT;
            rot       <= R_DISP;
            drv_valid <= 1'b0;
            drv_en    <= '0;
            drv_dir   <= 1'b0;
            illegal   <= 1'b0;
`ifdef CUBE_SEQ_TIMEOUT_EN
            wait_cnt  <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_INIT:  if (i_sense_start) state <= S_SOLVE;
                S_SOLVE: if (i_alg_finish && i_sd_done) state <= S_IDLE;
                S_IDLE: begin
                    if (i_run_start) begin
                        state <= S_ROTATE;
                        rot   <= R_DISP;
                    end
                end
                S_ROTATE: begin
                    case (rot)
                        R_DISP: begin
                            if (drv_valid) begin
                                if (bus.drv_ready) begin
                                    drv_valid <= 1'b0;
                                    drv_en    <= '0;
                                    drv_dir   <= 1'b0;
                                    rot       <= R_WAIT;
                                end
                            end else if (empty) begin
                                state <= S_DONE;
                            end else if (head_bad) begin
                                illegal <= 1'b1;
                            end else begin
                                drv_valid <= 1'b1;
                                drv_en    <= head_en;
                                drv_dir   <= head[0];
                            end
                        end
                        R_WAIT: begin
`ifdef CUBE_SEQ_TIMEOUT_EN
                            if (bus.drv_done) begin
                                wait_cnt <= '0;
                                rot      <= i_step_mode ? R_HOLD : R_DISP;
                            end else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
                                wait_cnt <= '0;
                                error_q  <= 1'b1;
                                state    <= S_ERROR;
                            end else begin
                                wait_cnt <= wait_cnt + TW'(1);
                            end
`else
                            if (bus.drv_done) rot <= i_step_mode ? R_HOLD : R_DISP;
`endif
                        end
                        R_HOLD:  if (i_run_start) rot <= R_DISP;
                        default: rot <= R_DISP;
                    endcase
                end
                S_DONE: begin
                    if (i_run_start) begin
                        state   <= S_INIT;
                        illegal <= 1'b0;
                    end
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.mv_ready  = mv_ready;
    assign bus.drv_valid = drv_valid;
    assign bus.drv_en    = drv_en;
    assign bus.drv_dir   = drv_dir;
    assign o_state       = state;
    assign o_count       = count;
    assign o_illegal     = illegal;
endmodule
